// File: rtl/fu_sequencer_if.sv
// Bus between the sequencer and its environment: program ROM port and FU datapath port.
interface fu_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] imem_addr;
  logic [15:0]       imem_data;
  logic [2:0]        fu_instr;
  logic [7:0]        fu_a;
  logic [7:0]        fu_b;
  logic [7:0]        fu_f;

  // Sequencer side: drives the ROM address and the FU opcode/operands.
  modport master (
    output imem_addr,
    output fu_instr,
    output fu_a,
    output fu_b,
    input  imem_data,
    input  fu_f
  );

  // ROM/FU side: returns the fetched word and the FU result.
  modport slave (
    input  imem_addr,
    input  fu_instr,
    input  fu_a,
    input  fu_b,
    output imem_data,
    output fu_f
  );
endinterface

// File: rtl/fu_sequencer.sv
// fu_sequencer: fetch/decode/execute front end for the 8-bit FU.
// Each instruction takes FETCH, DECODE and EXEC (3 cycles). One program runs per start pulse,
// from address 0 until a halt bit or the top ROM address.
// Word: [15]=1 LI  R[14:13] <= [7:0]
//       [15]=0 ALU R[11:10] <= FU([14:12], R[9:8], R[7:6])
//       [5] halt in both formats.
module fu_sequencer #(
  parameter int ADDR_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  fu_sequencer_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           overrun,
  input  logic [1:0]     dbg_sel,
  output logic [7:0]     dbg_data
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [ADDR_W-1:0] PC_TOP = '1;

  logic [2:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        regs [4];

  // Decoded instruction fields held from DECODE into EXEC.
  logic              ir_li;
  logic              ir_halt;
  logic [1:0]        ir_rd;
  logic [7:0]        ir_imm;

  // Word bits [4:0] carry no meaning in either format.
  logic              unused_bits;
  assign unused_bits = &{1'b0, bus.imem_data[4:0]};

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign dbg_data = regs[dbg_sel];

  // Sequencing FSM, FU opcode/operand registers and register-file write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments so every flop sees pre-edge values of the others.
      state        <= IDLE;
      pc           <= '0;
      bus.imem_addr <= '0;
      bus.fu_instr <= '0;
      bus.fu_a     <= '0;
      bus.fu_b     <= '0;
      overrun      <= 1'b0;
      ir_li        <= 1'b0;
      ir_halt      <= 1'b0;
      ir_rd        <= '0;
      ir_imm       <= '0;
      // NOTE: the register file is reset because R0..R3 are architecturally zero after rst.
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc            <= '0;
            bus.imem_addr <= '0;
            overrun       <= 1'b0;
            state         <= FETCH;
          end
        end

        // ROM word for imem_addr becomes valid one cycle after the address.
        FETCH: state <= DECODE;

        DECODE: begin
          ir_halt <= bus.imem_data[5];
          ir_imm  <= bus.imem_data[7:0];
          if (bus.imem_data[15]) begin
            ir_li <= 1'b1;
            ir_rd <= bus.imem_data[14:13];
          end else begin
            ir_li        <= 1'b0;
            ir_rd        <= bus.imem_data[11:10];
            bus.fu_instr <= bus.imem_data[14:12];
            bus.fu_a     <= regs[bus.imem_data[9:8]];
            bus.fu_b     <= regs[bus.imem_data[7:6]];
          end
          state <= EXEC;
        end

        EXEC: begin
          regs[ir_rd] <= ir_li ? ir_imm : bus.fu_f;
          if (ir_halt) begin
            state <= DONE;
          end else if (pc == PC_TOP) begin
            // Fell off the end of program space: stop rather than wrap.
            overrun <= 1'b1;
            state   <= DONE;
          end else begin
            pc            <= pc + 1'b1;
            bus.imem_addr <= pc + 1'b1;
            state         <= FETCH;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fu_sequencer.sv
// Self-checking bench for fu_sequencer: FU op table, hand-written timing/overrun/reset
// sequences, and random programs compared against a sequential program-level model.
module tb_fu_sequencer;

  localparam int AW  = 6;
  localparam int AW2 = 2;
  localparam int TOP = 2**AW - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  logic [1:0] dbg_sel = 2'd0;
  logic       busy, done, overrun;
  logic       busy2, done2, overrun2;
  logic [7:0] dbg_data, dbg_data2;

  fu_sequencer_if #(.ADDR_W(AW))  bus1 ();
  fu_sequencer_if #(.ADDR_W(AW2)) bus2 ();

  logic [15:0] rom  [2**AW];
  logic [15:0] rom2 [2**AW2];
  logic [7:0]  m_regs [4];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] f;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  // Stand-in for the Functional_Unit datapath.
  function automatic logic [7:0] fu_ref(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a + ~b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return {a[7], a[7:1]};
      3'd6:    return {a[0], a[7:1]};
      default: return {a[6:0], a[7]};
    endcase
  endfunction

  assign bus1.fu_f = fu_ref(bus1.fu_instr, bus1.fu_a, bus1.fu_b);
  assign bus2.fu_f = fu_ref(bus2.fu_instr, bus2.fu_a, bus2.fu_b);
  always @(posedge clk) bus1.imem_data <= rom[bus1.imem_addr];
  always @(posedge clk) bus2.imem_data <= rom2[bus2.imem_addr];

  fu_sequencer #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus1),
    .busy(busy), .done(done), .overrun(overrun),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  fu_sequencer #(.ADDR_W(AW2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(bus2),
    .busy(busy2), .done(done2), .overrun(overrun2),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data2)
  );

  function automatic logic [15:0] li_w(input logic [1:0] rd, input logic [7:0] imm);
    return {1'b1, rd, 5'b0, imm};
  endfunction

  function automatic logic [15:0] alu_w(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic [1:0] rb,
                                        input logic halt);
    return {1'b0, op, rd, ra, rb, halt, 5'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Program-level model: execute rom from address 0 in order until halt or top address.
  task automatic model_run(output int n, output bit ovr);
    logic [15:0] w;
    logic [7:0]  res;
    n   = 0;
    ovr = 1'b0;
    for (int pc = 0; pc <= TOP; pc++) begin
      w = rom[pc];
      n++;
      if (w[15]) begin
        m_regs[w[14:13]] = w[7:0];
      end else begin
        res = fu_ref(w[14:12], m_regs[w[9:8]], m_regs[w[7:6]]);
        m_regs[w[11:10]] = res;
      end
      if (w[5]) break;
      if (pc == TOP) ovr = 1'b1;
    end
  endtask

  task automatic check_regs(input string name);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      check($sformatf("%s R%0d", name, r), dbg_data, m_regs[r]);
    end
  endtask

  // Start the program in rom, optionally spraying start while busy, and check
  // latency, single-cycle done, overrun and the final register file.
  task automatic run_prog(input string name, input bit spray);
    int n_exp;
    bit ovr_exp;
    int c;
    bit seen;
    model_run(n_exp, ovr_exp);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c = 1;
    check($sformatf("%s busy after start", name), busy, 1);
    check($sformatf("%s overrun cleared", name), overrun, 0);
    seen = 1'b0;
    while (c < 3 * (TOP + 1) + 8) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (spray) start = 1'($urandom_range(0, 1));
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    check($sformatf("%s latency", name), seen ? c - 1 : 32'hFFFF, 3 * n_exp);
    check($sformatf("%s overrun", name), overrun, ovr_exp);
    @(negedge clk);
    check($sformatf("%s done one cycle", name), {busy, done}, 2'b00);
    check_regs(name);
  endtask

  // Load one register with a tiny program; a halting filler follows when imm[5]=0.
  task automatic load_reg(input logic [1:0] rd, input logic [7:0] imm);
    rom[0] = li_w(rd, imm);
    rom[1] = alu_w(3'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    run_prog("load", 1'b0);
  endtask

  initial begin
    int c;
    bit bad;

    vecs[0] = '{3'd0, 8'h05, 8'h03, 8'h08};
    vecs[1] = '{3'd1, 8'h05, 8'h03, 8'h01};
    vecs[2] = '{3'd2, 8'hF0, 8'h3C, 8'h30};
    vecs[3] = '{3'd3, 8'hF0, 8'h3C, 8'hFC};
    vecs[4] = '{3'd4, 8'hF0, 8'h3C, 8'hCC};
    vecs[5] = '{3'd5, 8'h81, 8'h00, 8'hC0};
    vecs[6] = '{3'd6, 8'h81, 8'h00, 8'hC0};
    vecs[7] = '{3'd7, 8'h81, 8'h00, 8'h03};

    for (int i = 0; i <= TOP; i++) rom[i] = 16'h0020;
    for (int i = 0; i < 4; i++) rom2[i] = 16'h0020;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset overrun", overrun, 0);
    check("reset imem_addr", bus1.imem_addr, 0);
    check("reset fu", {bus1.fu_instr, bus1.fu_a, bus1.fu_b}, 0);
    check_regs("reset");
    rst = 1'b0;

    // LI R1,05; LI R2,03; ADD R3,R1,R2 +halt: 9-cycle latency, R3=08.
    rom[0] = li_w(2'd1, 8'h05);
    rom[1] = li_w(2'd2, 8'h03);
    rom[2] = alu_w(3'd0, 2'd3, 2'd1, 2'd2, 1'b1);
    run_prog("add3", 1'b0);
    check("add3 R3", m_regs[3] == 8'h08 ? dbg_data : 32'hDEAD, 8'h08);
    check("add3 fu", {bus1.fu_instr, bus1.fu_a, bus1.fu_b}, {3'd0, 8'h05, 8'h03});

    // FU op table, one single-instruction program per entry.
    for (int i = 0; i < 8; i++) begin
      load_reg(2'd1, vecs[i].a);
      load_reg(2'd2, vecs[i].b);
      rom[0] = alu_w(vecs[i].op, 2'd3, 2'd1, 2'd2, 1'b1);
      run_prog($sformatf("op%0d", vecs[i].op), 1'b0);
      dbg_sel = 2'd3;
      #1;
      check($sformatf("op%0d R3", vecs[i].op), dbg_data, vecs[i].f);
      check($sformatf("op%0d fu", vecs[i].op), {bus1.fu_instr, bus1.fu_a, bus1.fu_b},
            {vecs[i].op, vecs[i].a, vecs[i].b});
    end

    // ADDR_W=2: four LIs without halt run off the top.
    rom2[0] = li_w(2'd0, 8'h01);
    rom2[1] = li_w(2'd1, 8'h02);
    rom2[2] = li_w(2'd2, 8'h03);
    rom2[3] = li_w(2'd3, 8'h04);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      c = 1;
      check($sformatf("aw2 pass%0d overrun cleared", pass), overrun2, 0);
      while (!done2 && c < 40) begin
        @(negedge clk);
        c++;
      end
      check($sformatf("aw2 pass%0d latency", pass), done2 ? c - 1 : 32'hFFFF, 12);
      check($sformatf("aw2 pass%0d overrun", pass), overrun2, 1);
      check($sformatf("aw2 pass%0d addr", pass), bus2.imem_addr, 3);
      @(negedge clk);
      check($sformatf("aw2 pass%0d done one cycle", pass), {busy2, done2}, 2'b00);
      dbg_sel = 2'd3;
      #1;
      check($sformatf("aw2 pass%0d R3", pass), dbg_data2, 8'h04);
    end

    // Random programs, with start sprayed while busy.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i <= TOP; i++) begin
        rom[i]    = 16'($urandom);
        rom[i][5] = (it != 0) && ($urandom_range(0, 7) == 0);
      end
      run_prog($sformatf("rand%0d", it), 1'b1);
    end

    // Reset during the 2nd instruction's EXEC.
    rom[0] = li_w(2'd0, 8'h11);
    rom[1] = li_w(2'd1, 8'h12);
    rom[2] = li_w(2'd2, 8'h13);
    rom[3] = li_w(2'd3, 8'h34);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (5) @(negedge clk);
    check("rst mid busy", busy, 1);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    check("rst mid busy low", busy, 0);
    check("rst mid done", done, 0);
    check("rst mid overrun", overrun, 0);
    check("rst mid imem_addr", bus1.imem_addr, 0);
    check("rst mid fu", {bus1.fu_instr, bus1.fu_a, bus1.fu_b}, 0);
    check_regs("rst mid");
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("rst mid quiet", bad, 0);
    run_prog("after rst", 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
